// File: rtl/data_mem_lsu_if.sv
// Memory-side bus of the load/store unit: single outstanding request,
// grant handshake, then a read-valid beat for loads.
interface data_mem_lsu_if;
  logic        Bus_Req;
  logic        Bus_We;
  logic [31:0] Bus_Addr;
  logic [3:0]  Bus_Be;
  logic [31:0] Bus_Wdata;
  logic        Bus_Gnt;
  logic        Bus_Rvalid;
  logic [31:0] Bus_Rdata;

  modport master (
    output Bus_Req,
    output Bus_We,
    output Bus_Addr,
    output Bus_Be,
    output Bus_Wdata,
    input  Bus_Gnt,
    input  Bus_Rvalid,
    input  Bus_Rdata
  );

  modport slave (
    input  Bus_Req,
    input  Bus_We,
    input  Bus_Addr,
    input  Bus_Be,
    input  Bus_Wdata,
    output Bus_Gnt,
    output Bus_Rvalid,
    output Bus_Rdata
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit between the core pipeline and a word-wide data bus:
// alignment check, byte-enable/lane replication, grant/response wait with timeout.
module data_mem_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic               Clk,
  input  logic               Reset_N,
  input  logic               Mem_Req,
  input  logic               Mem_Write,
  input  logic [2:0]         Lw_Sw_OP,
  input  logic [31:0]        Addr,
  input  logic [31:0]        Store_Data,
  output logic               Stall,
  output logic               Done,
  output logic               Err,
  output logic [31:0]        Data_Mem_Read,
  output logic [1:0]         Byte_Loc,
  output logic [2:0]         Lw_Sw_OP_Out,
  data_mem_lsu_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic        err_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        timed_out;
  logic        capture;
  logic        bus_capture;
  logic        set_err;
  logic        cnt_clr;
  logic        load_rdata;

  // Undefined funct3 encodings fall through to the misaligned path so they never reach the bus.
  always_comb begin
    misaligned = 1'b1;
    case (Lw_Sw_OP)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = Addr[0];
      3'b010:         misaligned = |Addr[1:0];
      default:        misaligned = 1'b1;
    endcase
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = Store_Data;
    if (Mem_Write) begin
      case (Lw_Sw_OP[1:0])
        2'b00: begin
          be_next    = 4'b0001 << Addr[1:0];
          wdata_next = {4{Store_Data[7:0]}};
        end
        2'b01: begin
          be_next    = Addr[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{Store_Data[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = Store_Data;
        end
      endcase
    end
  end

  assign timed_out = (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A grant or response arriving in the same cycle as the timeout still completes normally.
  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    bus_capture = 1'b0;
    set_err     = 1'b0;
    cnt_clr     = 1'b0;
    load_rdata  = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_Req) begin
          capture = 1'b1;
          if (misaligned) begin
            set_err    = 1'b1;
            next_state = DONE;
          end else begin
            bus_capture = 1'b1;
            cnt_clr     = 1'b1;
            next_state  = REQ;
          end
        end
      end
      REQ: begin
        if (bus.Bus_Gnt) begin
          if (we_q) begin
            next_state = DONE;
          end else begin
            cnt_clr    = 1'b1;
            next_state = WAIT_R;
          end
        end else if (timed_out) begin
          set_err    = 1'b1;
          next_state = DONE;
        end
      end
      WAIT_R: begin
        if (bus.Bus_Rvalid) begin
          load_rdata = 1'b1;
          next_state = DONE;
        end else if (timed_out) begin
          set_err    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      wait_cnt <= 8'd0;
    end else if (cnt_clr) begin
      wait_cnt <= 8'd0;
    end else if (state == REQ || state == WAIT_R) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Capture clears a stale error; a later timeout can still raise it before DONE.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      err_q        <= 1'b0;
      Byte_Loc     <= 2'b00;
      Lw_Sw_OP_Out <= 3'b000;
    end else begin
      if (capture || set_err) begin
        err_q <= set_err;
      end
      if (capture) begin
        Byte_Loc     <= Addr[1:0];
        Lw_Sw_OP_Out <= Lw_Sw_OP;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
    end else if (bus_capture) begin
      we_q    <= Mem_Write;
      addr_q  <= {Addr[31:2], 2'b00};
      be_q    <= be_next;
      wdata_q <= wdata_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      Data_Mem_Read <= 32'd0;
    end else if (load_rdata) begin
      Data_Mem_Read <= bus.Bus_Rdata;
    end
  end

  assign Stall         = Mem_Req && (state != DONE);
  assign Done          = (state == DONE);
  assign Err           = (state == DONE) && err_q;
  assign bus.Bus_Req   = (state == REQ);
  assign bus.Bus_We    = we_q;
  assign bus.Bus_Addr  = addr_q;
  assign bus.Bus_Be    = be_q;
  assign bus.Bus_Wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: a scoreboard holds the expected completion of
// each request and is popped when Done pulses; a bus responder replays grant/rvalid delays.
module tb_data_mem_lsu;

  typedef struct {
    logic        isWrite;
    logic [31:0] busAddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] readData;
    logic        err;
    logic [1:0]  byteLoc;
    logic [2:0]  op;
    int          reqCycles;
    int          latency;
  } expTxn_t;

  logic        Clk;
  logic        Reset_N;
  logic        Mem_Req;
  logic        Mem_Write;
  logic [2:0]  Lw_Sw_OP;
  logic [31:0] Addr;
  logic [31:0] Store_Data;
  logic        Stall;
  logic        Done;
  logic        Err;
  logic [31:0] Data_Mem_Read;
  logic [1:0]  Byte_Loc;
  logic [2:0]  Lw_Sw_OP_Out;

  data_mem_lsu_if bus ();

  data_mem_lsu #(.TIMEOUT(64)) dut (
    .Clk           (Clk),
    .Reset_N       (Reset_N),
    .Mem_Req       (Mem_Req),
    .Mem_Write     (Mem_Write),
    .Lw_Sw_OP      (Lw_Sw_OP),
    .Addr          (Addr),
    .Store_Data    (Store_Data),
    .Stall         (Stall),
    .Done          (Done),
    .Err           (Err),
    .Data_Mem_Read (Data_Mem_Read),
    .Byte_Loc      (Byte_Loc),
    .Lw_Sw_OP_Out  (Lw_Sw_OP_Out),
    .bus           (bus)
  );

  expTxn_t     sb[$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;
  logic [31:0] lastRead   = 32'd0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".Stall"},         32'(Stall),         32'd0);
    checkOutput({tag, ".Done"},          32'(Done),          32'd0);
    checkOutput({tag, ".Err"},           32'(Err),           32'd0);
    checkOutput({tag, ".Data_Mem_Read"}, Data_Mem_Read,      32'd0);
    checkOutput({tag, ".Byte_Loc"},      32'(Byte_Loc),      32'd0);
    checkOutput({tag, ".Lw_Sw_OP_Out"},  32'(Lw_Sw_OP_Out),  32'd0);
    checkOutput({tag, ".Bus_Req"},       32'(bus.Bus_Req),   32'd0);
    checkOutput({tag, ".Bus_We"},        32'(bus.Bus_We),    32'd0);
    checkOutput({tag, ".Bus_Addr"},      bus.Bus_Addr,       32'd0);
    checkOutput({tag, ".Bus_Be"},        32'(bus.Bus_Be),    32'd0);
    checkOutput({tag, ".Bus_Wdata"},     bus.Bus_Wdata,      32'd0);
  endtask

  // gntDelay/rvDelay = number of cycles the responder withholds the strobe; negative = never.
  task automatic applyStimulus(
    input string       tag,
    input logic        wr,
    input logic [2:0]  op,
    input logic [31:0] addr,
    input logic [31:0] sdata,
    input int          gntDelay,
    input int          rvDelay,
    input logic [31:0] rdata,
    input logic [31:0] expBusAddr,
    input logic [3:0]  expBe,
    input logic [31:0] expWdata,
    input logic        expErr,
    input int          expReqCycles,
    input int          expLatency
  );
    expTxn_t e;
    expTxn_t got;
    int      k;
    int      reqCycles;
    int      waitCycles;
    int      stallBad;
    bit      finished;
    bit      busChecked;
    bit      granted;

    e.isWrite   = wr;
    e.busAddr   = expBusAddr;
    e.be        = expBe;
    e.wdata     = expWdata;
    e.readData  = (!wr && !expErr) ? rdata : lastRead;
    e.err       = expErr;
    e.byteLoc   = addr[1:0];
    e.op        = op;
    e.reqCycles = expReqCycles;
    e.latency   = expLatency;
    sb.push_back(e);

    Mem_Req    = 1'b1;
    Mem_Write  = wr;
    Lw_Sw_OP   = op;
    Addr       = addr;
    Store_Data = sdata;

    k          = 0;
    reqCycles  = 0;
    waitCycles = 0;
    stallBad   = 0;
    finished   = 1'b0;
    busChecked = 1'b0;
    granted    = 1'b0;

    while (!finished && k < 300) begin
      @(negedge Clk);
      k++;
      if (Done) begin
        got = sb.pop_front();
        checkOutput({tag, ".latency"},   32'(k),            32'(got.latency));
        checkOutput({tag, ".Err"},       32'(Err),          32'(got.err));
        checkOutput({tag, ".rdata"},     Data_Mem_Read,     got.readData);
        checkOutput({tag, ".Byte_Loc"},  32'(Byte_Loc),     32'(got.byteLoc));
        checkOutput({tag, ".opOut"},     32'(Lw_Sw_OP_Out), 32'(got.op));
        checkOutput({tag, ".busReqOff"}, 32'(bus.Bus_Req),  32'd0);
        checkOutput({tag, ".stallDone"}, 32'(Stall),        32'd0);
        checkOutput({tag, ".reqCycles"}, 32'(reqCycles),    32'(got.reqCycles));
        checkOutput({tag, ".stallHeld"}, 32'(stallBad),     32'd0);
        lastRead       = got.readData;
        finished       = 1'b1;
        Mem_Req        = 1'b0;
        bus.Bus_Gnt    = 1'b0;
        bus.Bus_Rvalid = 1'b0;
      end else begin
        if (Stall !== 1'b1) stallBad++;
        if (bus.Bus_Req) begin
          reqCycles++;
          if (!busChecked) begin
            busChecked = 1'b1;
            checkOutput({tag, ".Bus_Addr"}, bus.Bus_Addr,     sb[0].busAddr);
            checkOutput({tag, ".Bus_Be"},   32'(bus.Bus_Be),  32'(sb[0].be));
            checkOutput({tag, ".Bus_We"},   32'(bus.Bus_We),  32'(sb[0].isWrite));
            if (sb[0].isWrite) checkOutput({tag, ".Bus_Wdata"}, bus.Bus_Wdata, sb[0].wdata);
          end
          bus.Bus_Gnt = (gntDelay >= 0) && (reqCycles > gntDelay);
          if (bus.Bus_Gnt) granted = 1'b1;
        end else begin
          bus.Bus_Gnt = 1'b0;
          if (granted && !wr) begin
            waitCycles++;
            bus.Bus_Rvalid = (rvDelay >= 0) && (waitCycles > rvDelay);
            bus.Bus_Rdata  = bus.Bus_Rvalid ? rdata : 32'hBAD0_BAD0;
          end
        end
      end
    end

    if (!finished) begin
      checkOutput({tag, ".doneSeen"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      Mem_Req        = 1'b0;
      bus.Bus_Gnt    = 1'b0;
      bus.Bus_Rvalid = 1'b0;
    end else begin
      @(negedge Clk);
      checkOutput({tag, ".donePulse"}, 32'(Done), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;

    Reset_N        = 1'b0;
    Mem_Req        = 1'b0;
    Mem_Write      = 1'b0;
    Lw_Sw_OP       = 3'b000;
    Addr           = 32'd0;
    Store_Data     = 32'd0;
    bus.Bus_Gnt    = 1'b0;
    bus.Bus_Rvalid = 1'b0;
    bus.Bus_Rdata  = 32'd0;

    #1;
    checkAllZero("reset");
    @(negedge Clk);
    @(negedge Clk);
    Reset_N = 1'b1;
    @(negedge Clk);
    checkOutput("idle.busReq", 32'(bus.Bus_Req), 32'd0);
    checkOutput("idle.stall",  32'(Stall),       32'd0);

    $display("[TB] directed transactions");
    applyStimulus("sw100",  1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'd0,
                  32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1, 2);
    applyStimulus("sb203",  1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'd0,
                  32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 1'b0, 1, 2);
    applyStimulus("lh302",  1'b0, 3'b001, 32'h0000_0302, 32'h0,         3, 2, 32'h8001_1234,
                  32'h0000_0300, 4'b1111, 32'h0,         1'b0, 4, 8);
    applyStimulus("sh102",  1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 1, 0, 32'd0,
                  32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 1'b0, 2, 3);
    applyStimulus("sh020",  1'b1, 3'b101, 32'h0000_0020, 32'hFFFF_5A3C, 0, 0, 32'd0,
                  32'h0000_0020, 4'b0011, 32'h5A3C_5A3C, 1'b0, 1, 2);
    applyStimulus("lw401",  1'b0, 3'b010, 32'h0000_0401, 32'h0,         0, 0, 32'd0,
                  32'h0,         4'b0000, 32'h0,         1'b1, 0, 1);
    applyStimulus("shA01",  1'b1, 3'b001, 32'h0000_0A01, 32'h0000_7777, 0, 0, 32'd0,
                  32'h0,         4'b0000, 32'h0,         1'b1, 0, 1);
    applyStimulus("op011",  1'b1, 3'b011, 32'h0000_0700, 32'h0000_1111, 0, 0, 32'd0,
                  32'h0,         4'b0000, 32'h0,         1'b1, 0, 1);
    applyStimulus("lbuTmo", 1'b0, 3'b100, 32'h0000_0605, 32'h0,        -1, 0, 32'd0,
                  32'h0000_0604, 4'b1111, 32'h0,         1'b1, 64, 65);
    applyStimulus("lb803",  1'b0, 3'b000, 32'h0000_0803, 32'h0,         0, 0, 32'h1234_5678,
                  32'h0000_0800, 4'b1111, 32'h0,         1'b0, 1, 3);
    applyStimulus("lhuTmo", 1'b0, 3'b101, 32'h0000_0900, 32'h0,         0, -1, 32'd0,
                  32'h0000_0900, 4'b1111, 32'h0,         1'b1, 1, 66);

    $display("[TB] reset during WAIT_R");
    Mem_Req   = 1'b1;
    Mem_Write = 1'b0;
    Lw_Sw_OP  = 3'b010;
    Addr      = 32'h0000_0500;
    @(negedge Clk);
    checkOutput("midrst.inReq", 32'(bus.Bus_Req), 32'd1);
    bus.Bus_Gnt = 1'b1;
    @(negedge Clk);
    bus.Bus_Gnt = 1'b0;
    @(negedge Clk);
    checkOutput("midrst.waitStall", 32'(Stall), 32'd1);
    #2;
    Reset_N = 1'b0;
    Mem_Req = 1'b0;
    #1;
    checkAllZero("midrst");
    @(negedge Clk);
    @(negedge Clk);
    Reset_N        = 1'b1;
    bus.Bus_Rvalid = 1'b1;
    bus.Bus_Rdata  = 32'hCAFE_F00D;
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Done) doneSeen++;
    end
    bus.Bus_Rvalid = 1'b0;
    checkOutput("midrst.noDone", 32'(doneSeen),    32'd0);
    checkOutput("midrst.rdata",  Data_Mem_Read,    32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
